multiport_register_file: RTL and testbench

- Parametrised integer register file for the next-generation pipelined core.
- Provides N combinational read ports and two synchronous write ports (W0 = ALU/early writeback, W1 = load/late writeback).
- Optional read-during-write bypass.
- Per-register pending-write scoreboard, so decode can detect RAW hazards and stall.
- Debug read port replaces the fixed register-31 tap.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/reg_scoreboard.sv | 70 +++++++
 rtl/multiport_register_file.sv | 102 ++++++++++
 tb/tb_multiport_register_file.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the integer register file.
package regfile_pkg;

    localparam int unsigned DefaultXlen    = 32;
    localparam int unsigned DefaultNumRegs = 32;
    localparam int unsigned DefaultAw      = $clog2(DefaultNumRegs);

    typedef logic [DefaultAw-1:0] reg_addr_t;

    // 'release' is a language keyword, so the release flag is named rel.
    typedef struct packed {
        logic                   en;
        reg_addr_t              addr;
        logic [DefaultXlen-1:0] data;
        logic                   rel;
    } wr_port_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write bits with reserve/release/flush priority,
// a registered popcount and the un-bypassed busy lookup for each read port.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS       = DefaultNumRegs,
    parameter int unsigned NUM_READ_PORTS = 2,
    parameter int unsigned AW             = $clog2(NUM_REGS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       rsv_en,
    input  logic [AW-1:0]              rsv_addr,
    input  logic                       rel0_en,
    input  logic [AW-1:0]              rel0_addr,
    input  logic                       rel1_en,
    input  logic [AW-1:0]              rel1_addr,
    input  logic [NUM_READ_PORTS*AW-1:0] rd_addr,
    output logic [NUM_READ_PORTS-1:0]  rd_busy,
    output logic [AW:0]                busy_count
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [AW:0]         count_d;

    // Next busy bits: flush, then reserve (a new producer), then release, then hold.
    always_comb begin
        busy_d    = busy_q;
        busy_d[0] = 1'b0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (rsv_en && rsv_addr == AW'(r)) begin
                busy_d[r] = 1'b1;
            end else if ((rel0_en && rel0_addr == AW'(r)) ||
                         (rel1_en && rel1_addr == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    // Popcount of the next-state bits so the count moves on the same edge.
    always_comb begin
        count_d = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            count_d = count_d + (AW+1)'(busy_d[r]);
        end
    end

    // Busy bits and count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q     <= '0;
            busy_count <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_count <= count_d;
        end
    end

    // Stored busy bit for each read port; bit 0 is never set.
    always_comb begin
        rd_busy = '0;
        for (int unsigned k = 0; k < NUM_READ_PORTS; k++) begin
            rd_busy[k] = busy_q[rd_addr[k*AW +: AW]];
        end
    end

endmodule

// File: rtl/multiport_register_file.sv
// Integer register file: N combinational read ports, two write ports,
// optional read-during-write bypass, pending-write scoreboard and debug tap.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN           = DefaultXlen,
    parameter int unsigned NUM_REGS       = DefaultNumRegs,
    parameter int unsigned NUM_READ_PORTS = 2,
    parameter bit          BYPASS         = 1'b1,
    parameter int unsigned AW             = $clog2(NUM_REGS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_READ_PORTS*AW-1:0]   rd_addr,
    output logic [NUM_READ_PORTS*XLEN-1:0] rd_data,
    output logic [NUM_READ_PORTS-1:0]      rd_busy,
    input  logic                           wr0_en,
    input  logic [AW-1:0]                  wr0_addr,
    input  logic [XLEN-1:0]                wr0_data,
    input  logic                           wr0_release,
    input  logic                           wr1_en,
    input  logic [AW-1:0]                  wr1_addr,
    input  logic [XLEN-1:0]                wr1_data,
    input  logic                           wr1_release,
    input  logic                           rsv_en,
    input  logic [AW-1:0]                  rsv_addr,
    input  logic                           flush,
    input  logic [AW-1:0]                  dbg_addr,
    output logic [XLEN-1:0]                dbg_data,
    output logic [AW:0]                    busy_count
);

    logic [XLEN-1:0]           mem_q [NUM_REGS];
    logic [NUM_READ_PORTS-1:0] sb_busy;
    logic                      rel0_en, rel1_en;

    assign rel0_en = wr0_en && wr0_release;
    assign rel1_en = wr1_en && wr1_release;

    reg_scoreboard #(
        .NUM_REGS       (NUM_REGS),
        .NUM_READ_PORTS (NUM_READ_PORTS),
        .AW             (AW)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .rel0_en    (rel0_en),
        .rel0_addr  (wr0_addr),
        .rel1_en    (rel1_en),
        .rel1_addr  (wr1_addr),
        .rd_addr    (rd_addr),
        .rd_busy    (sb_busy),
        .busy_count (busy_count)
    );

    // Storage; W1 is applied last so it wins on an address collision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            if (wr0_en && wr0_addr != '0) begin
                mem_q[wr0_addr] <= wr0_data;
            end
            if (wr1_en && wr1_addr != '0) begin
                mem_q[wr1_addr] <= wr1_data;
            end
        end
    end

    // Read ports with optional bypass of same-cycle write data and release.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NUM_READ_PORTS; k++) begin
            logic [AW-1:0] a;
            a = rd_addr[k*AW +: AW];
            if (a == '0) begin
                rd_data[k*XLEN +: XLEN] = '0;
            end else if (BYPASS && wr1_en && wr1_addr == a) begin
                rd_data[k*XLEN +: XLEN] = wr1_data;
            end else if (BYPASS && wr0_en && wr0_addr == a) begin
                rd_data[k*XLEN +: XLEN] = wr0_data;
            end else begin
                rd_data[k*XLEN +: XLEN] = mem_q[a];
            end
            rd_busy[k] = sb_busy[k] &&
                         !(BYPASS && ((rel0_en && wr0_addr == a) ||
                                      (rel1_en && wr1_addr == a)));
        end
    end

    // Debug tap reads stored contents only.
    always_comb begin
        dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed self-checking bench for multiport_register_file (default parameters).
module tb_multiport_register_file;

    localparam int AW = 5;
    localparam int XL = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [2*AW-1:0] rd_addr;
    logic [2*XL-1:0] rd_data;
    logic [1:0]    rd_busy;
    logic          wr0_en, wr0_release, wr1_en, wr1_release, rsv_en, flush;
    logic [AW-1:0] wr0_addr, wr1_addr, rsv_addr, dbg_addr;
    logic [XL-1:0] wr0_data, wr1_data, dbg_data;
    logic [AW:0]   busy_count;

    int errors = 0;
    int checks = 0;

    multiport_register_file dut (
        .clock       (clock),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr0_en      (wr0_en),
        .wr0_addr    (wr0_addr),
        .wr0_data    (wr0_data),
        .wr0_release (wr0_release),
        .wr1_en      (wr1_en),
        .wr1_addr    (wr1_addr),
        .wr1_data    (wr1_data),
        .wr1_release (wr1_release),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .flush       (flush),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .busy_count  (busy_count)
    );

    always #5 clock = ~clock;

    task automatic idle();
        wr0_en = 0; wr0_addr = 0; wr0_data = 0; wr0_release = 0;
        wr1_en = 0; wr1_addr = 0; wr1_data = 0; wr1_release = 0;
        rsv_en = 0; rsv_addr = 0; flush = 0;
    endtask

    // Advance one edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; idle(); rd_addr = {5'd5, 5'd5}; dbg_addr = 5'd5;
        #2;
        checks++; if (rd_data !== 64'h0) begin errors++;
            $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        checks++; if (rd_busy !== 2'b00) begin errors++;
            $display("FAIL reset_rd_busy got %b exp 00", rd_busy); end
        checks++; if (busy_count !== 6'd0) begin errors++;
            $display("FAIL reset_busy_count got %0d exp 0", busy_count); end
        checks++; if (dbg_data !== 32'h0) begin errors++;
            $display("FAIL reset_dbg got %h exp 0", dbg_data); end
        tick(); reset = 0; tick();
    endtask

    task automatic test_write_read();
        wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        tick(); idle();
        rd_addr = {5'd0, 5'd5}; dbg_addr = 5'd5; #1;
        checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++;
            $display("FAIL wr_rd5 got %h exp deadbeef", rd_data[31:0]); end
        checks++; if (dbg_data !== 32'hDEADBEEF) begin errors++;
            $display("FAIL dbg5 got %h exp deadbeef", dbg_data); end
        #2 reset = 1; #1;
        checks++; if (rd_data[31:0] !== 32'h0) begin errors++;
            $display("FAIL async_reset_rd got %h exp 0", rd_data[31:0]); end
        checks++; if (dbg_data !== 32'h0) begin errors++;
            $display("FAIL async_reset_dbg got %h exp 0", dbg_data); end
        tick(); reset = 0; tick();
    endtask

    task automatic test_zero_reg();
        wr0_en = 1; wr0_addr = 5'd0; wr0_data = 32'h12345678; wr0_release = 1;
        rsv_en = 1; rsv_addr = 5'd0; rd_addr = {5'd0, 5'd0}; #1;
        checks++; if (rd_data[31:0] !== 32'h0) begin errors++;
            $display("FAIL zero_bypass got %h exp 0", rd_data[31:0]); end
        tick(); idle(); #1;
        checks++; if (rd_data[31:0] !== 32'h0) begin errors++;
            $display("FAIL zero_rd got %h exp 0", rd_data[31:0]); end
        checks++; if (rd_busy[0] !== 1'b0) begin errors++;
            $display("FAIL zero_busy got %b exp 0", rd_busy[0]); end
        checks++; if (busy_count !== 6'd0) begin errors++;
            $display("FAIL zero_count got %0d exp 0", busy_count); end
    endtask

    task automatic test_same_addr();
        wr0_en = 1; wr0_addr = 5'd7; wr0_data = 32'h11;
        wr1_en = 1; wr1_addr = 5'd7; wr1_data = 32'h22;
        rd_addr = {5'd7, 5'd0}; dbg_addr = 5'd7; #1;
        checks++; if (rd_data[63:32] !== 32'h22) begin errors++;
            $display("FAIL bypass_w1_wins got %h exp 22", rd_data[63:32]); end
        checks++; if (dbg_data !== 32'h0) begin errors++;
            $display("FAIL dbg_no_bypass got %h exp 0", dbg_data); end
        tick(); idle(); #1;
        checks++; if (rd_data[63:32] !== 32'h22) begin errors++;
            $display("FAIL stored_w1_wins got %h exp 22", rd_data[63:32]); end
        checks++; if (dbg_data !== 32'h22) begin errors++;
            $display("FAIL dbg7 got %h exp 22", dbg_data); end
        // Lone W0 bypass on the other port.
        wr0_en = 1; wr0_addr = 5'd8; wr0_data = 32'h88; rd_addr = {5'd0, 5'd8}; #1;
        checks++; if (rd_data[31:0] !== 32'h88) begin errors++;
            $display("FAIL bypass_w0 got %h exp 88", rd_data[31:0]); end
        tick(); idle();
    endtask

    task automatic test_reserve_release();
        rsv_en = 1; rsv_addr = 5'd9;
        tick(); idle(); rd_addr = {5'd0, 5'd9}; #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++;
            $display("FAIL rsv9_busy got %b exp 1", rd_busy[0]); end
        checks++; if (busy_count !== 6'd1) begin errors++;
            $display("FAIL rsv9_count got %0d exp 1", busy_count); end
        // Write without release leaves the bit set.
        wr0_en = 1; wr0_addr = 5'd9; wr0_data = 32'h99;
        tick(); idle(); #1;
        checks++; if (rd_busy[0] !== 1'b1 || busy_count !== 6'd1) begin errors++;
            $display("FAIL norel_busy got %b/%0d exp 1/1", rd_busy[0], busy_count); end
        wr1_en = 1; wr1_addr = 5'd9; wr1_data = 32'hAB; wr1_release = 1; #1;
        checks++; if (rd_busy[0] !== 1'b0) begin errors++;
            $display("FAIL rel_bypass_busy got %b exp 0", rd_busy[0]); end
        checks++; if (rd_data[31:0] !== 32'hAB) begin errors++;
            $display("FAIL rel_bypass_data got %h exp ab", rd_data[31:0]); end
        checks++; if (busy_count !== 6'd1) begin errors++;
            $display("FAIL rel_count_before got %0d exp 1", busy_count); end
        tick(); idle(); #1;
        checks++; if (busy_count !== 6'd0) begin errors++;
            $display("FAIL rel_count_after got %0d exp 0", busy_count); end
        checks++; if (rd_busy[0] !== 1'b0) begin errors++;
            $display("FAIL rel_busy_after got %b exp 0", rd_busy[0]); end
    endtask

    task automatic test_reserve_priority();
        rsv_en = 1; rsv_addr = 5'd3;
        tick(); idle();
        rsv_en = 1; rsv_addr = 5'd3;
        wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'h33; wr0_release = 1;
        tick(); idle(); rd_addr = {5'd0, 5'd3}; #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++;
            $display("FAIL rsv_over_rel_busy got %b exp 1", rd_busy[0]); end
        checks++; if (busy_count !== 6'd1) begin errors++;
            $display("FAIL rsv_over_rel_count got %0d exp 1", busy_count); end
        // Release without enable is ignored.
        wr0_release = 1; wr0_addr = 5'd3;
        tick(); idle(); #1;
        checks++; if (busy_count !== 6'd1) begin errors++;
            $display("FAIL rel_no_en got %0d exp 1", busy_count); end
        wr1_en = 1; wr1_addr = 5'd3; wr1_data = 32'h33; wr1_release = 1;
        tick(); idle(); #1;
        checks++; if (busy_count !== 6'd0) begin errors++;
            $display("FAIL rel3_count got %0d exp 0", busy_count); end
    endtask

    task automatic test_flush();
        rsv_en = 1; rsv_addr = 5'd1; tick();
        rsv_addr = 5'd2; tick();
        rsv_addr = 5'd31; tick(); idle();
        rd_addr = {5'd31, 5'd2}; #1;
        checks++; if (busy_count !== 6'd3) begin errors++;
            $display("FAIL three_count got %0d exp 3", busy_count); end
        checks++; if (rd_busy !== 2'b11) begin errors++;
            $display("FAIL three_busy got %b exp 11", rd_busy); end
        flush = 1; tick(); idle();
        rd_addr = {5'd1, 5'd9}; dbg_addr = 5'd3; #1;
        checks++; if (busy_count !== 6'd0) begin errors++;
            $display("FAIL flush_count got %0d exp 0", busy_count); end
        checks++; if (rd_busy !== 2'b00) begin errors++;
            $display("FAIL flush_busy got %b exp 00", rd_busy); end
        checks++; if (rd_data[31:0] !== 32'hAB) begin errors++;
            $display("FAIL flush_keep9 got %h exp ab", rd_data[31:0]); end
        checks++; if (dbg_data !== 32'h33) begin errors++;
            $display("FAIL flush_keep3 got %h exp 33", dbg_data); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_same_addr();
        test_reserve_release();
        test_reserve_priority();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
